key_debouncer_repeat: RTL and testbench

- Consumes the periodic strobe of the strobe generator (one-cycle pulse every N clocks) as its sample tick.
- Turns a raw, bouncing push-button input into:
  - a clean debounced level;
  - one-clock press and release pulses;
  - a long-press pulse;
  - auto-repeat pulses while the key stays held.
- Sits between the strobe generator and keypad/menu logic.

---
 rtl/key_debouncer_repeat.sv | 201 ++++++++++++++++++++
 tb/tb_key_debouncer_repeat.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debouncer_repeat.sv
// Push-button debouncer with press/release pulses, a long-press pulse and
// auto-repeat while held. Samples the synchronized button on each Strobe_i
// tick; all outputs are registered.
module key_debouncer_repeat #(
   parameter int ACTIVE_LOW       = 1,
   parameter int DEBOUNCE_SAMPLES = 4,
   parameter int LONG_SAMPLES     = 100,
   parameter int REPEAT_SAMPLES   = 20
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Enable_i,
   input  logic Strobe_i,
   input  logic Button_i,
   output logic State_o,
   output logic Press_o,
   output logic Release_o,
   output logic LongPress_o,
   output logic Repeat_o
);

   localparam int DEB_W    = $clog2(DEBOUNCE_SAMPLES) + 1;
   localparam int HOLD_MAX = (LONG_SAMPLES > REPEAT_SAMPLES) ? LONG_SAMPLES : REPEAT_SAMPLES;
   localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SAMPLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_SAMPLES - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_SAMPLES - 1);

   // Raw pin level that means "not pressed"
   localparam logic RELEASED_PIN = (ACTIVE_LOW != 0);

   typedef enum logic [2:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      REPEAT,
      DEB_RELEASE
   } fsm_t;

   // Which held state a release bounce returns to
   typedef enum logic {
      ORIG_PRESSED,
      ORIG_REPEAT
   } origin_t;

   logic              sync1_q, sync1_d;
   logic              sync2_q, sync2_d;
   fsm_t              fsm_q, fsm_d;
   origin_t           origin_q, origin_d;
   logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;
   logic              repeat_q, repeat_d;

   logic sample;

   // Synchronized pin normalized to 1 = pressed
   assign sample = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

   // Next-state logic: synchronizer shift, debounce FSM, hold timing and pulses
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      sync1_d    = Button_i;
      sync2_d    = sync1_q;
      fsm_d      = fsm_q;
      origin_d   = origin_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      level_d    = level_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;

      if (!Enable_i) begin
         fsm_d      = IDLE;
         origin_d   = ORIG_PRESSED;
         deb_cnt_d  = '0;
         hold_cnt_d = '0;
         level_d    = 1'b0;
      end else if (Strobe_i) begin
         unique case (fsm_q)
            IDLE: begin
               level_d = 1'b0;
               if (sample) begin
                  fsm_d     = DEB_PRESS;
                  deb_cnt_d = DEB_W'(1);
               end
            end

            DEB_PRESS: begin
               if (!sample) begin
                  fsm_d     = IDLE;
                  deb_cnt_d = '0;
               end else if (deb_cnt_q == DEB_LAST) begin
                  fsm_d      = PRESSED;
                  level_d    = 1'b1;
                  press_d    = 1'b1;
                  hold_cnt_d = '0;
                  deb_cnt_d  = '0;
               end else begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
               end
            end

            PRESSED: begin
               if (!sample) begin
                  fsm_d     = DEB_RELEASE;
                  origin_d  = ORIG_PRESSED;
                  deb_cnt_d = DEB_W'(1);
               end else if (hold_cnt_q == LONG_LAST) begin
                  fsm_d      = REPEAT;
                  long_d     = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            REPEAT: begin
               if (!sample) begin
                  fsm_d     = DEB_RELEASE;
                  origin_d  = ORIG_REPEAT;
                  deb_cnt_d = DEB_W'(1);
               end else if (hold_cnt_q == REP_LAST) begin
                  repeat_d   = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end

            DEB_RELEASE: begin
               // hold_cnt stays frozen so a bounce does not restart hold timing
               if (sample) begin
                  fsm_d     = (origin_q == ORIG_REPEAT) ? REPEAT : PRESSED;
                  deb_cnt_d = '0;
               end else if (deb_cnt_q == DEB_LAST) begin
                  fsm_d      = IDLE;
                  level_d    = 1'b0;
                  release_d  = 1'b1;
                  deb_cnt_d  = '0;
                  hold_cnt_d = '0;
               end else begin
                  deb_cnt_d = deb_cnt_q + 1'b1;
               end
            end

            default: begin
               fsm_d      = IDLE;
               deb_cnt_d  = '0;
               hold_cnt_d = '0;
               level_d    = 1'b0;
            end
         endcase
      end
   end

   // State registers; the synchronizer resets to the released pin level
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync1_q    <= RELEASED_PIN;
         sync2_q    <= RELEASED_PIN;
         fsm_q      <= IDLE;
         origin_q   <= ORIG_PRESSED;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         level_q    <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         fsm_q      <= fsm_d;
         origin_q   <= origin_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   assign State_o     = level_q;
   assign Press_o     = press_q;
   assign Release_o   = release_q;
   assign LongPress_o = long_q;
   assign Repeat_o    = repeat_q;

endmodule

// File: tb/tb_key_debouncer_repeat.sv
// Bench for key_debouncer_repeat: an abstract run-length/hold-count model
// checked every cycle on two instances (active-low with a 1-in-10 strobe,
// active-high with the strobe tied high), plus literal pulse-timing checks.
`timescale 1ns/1ps
module tb_key_debouncer_repeat;

   localparam int DEB  = 4;
   localparam int LONG = 10;
   localparam int REP  = 3;

   logic Clock = 1'b0;
   logic Reset;
   logic Enable_i;
   logic strobe_a;
   logic button_a;
   logic button_b;

   logic state_a, press_a, rel_a, lp_a, rep_a;
   logic state_b, press_b, rel_b, lp_b, rep_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   key_debouncer_repeat #(
      .ACTIVE_LOW(1), .DEBOUNCE_SAMPLES(DEB), .LONG_SAMPLES(LONG), .REPEAT_SAMPLES(REP)
   ) dut_a (
      .Clock(Clock), .Reset(Reset), .Enable_i(Enable_i), .Strobe_i(strobe_a),
      .Button_i(button_a), .State_o(state_a), .Press_o(press_a), .Release_o(rel_a),
      .LongPress_o(lp_a), .Repeat_o(rep_a)
   );

   key_debouncer_repeat #(
      .ACTIVE_LOW(0), .DEBOUNCE_SAMPLES(DEB), .LONG_SAMPLES(LONG), .REPEAT_SAMPLES(REP)
   ) dut_b (
      .Clock(Clock), .Reset(Reset), .Enable_i(Enable_i), .Strobe_i(1'b1),
      .Button_i(button_b), .State_o(state_b), .Press_o(press_b), .Release_o(rel_b),
      .LongPress_o(lp_b), .Repeat_o(rep_b)
   );

   // ---------------------------------------------------------------- checks
   task automatic note_fail(input string name, input string act, input string exp);
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %s, expected %s (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) note_fail(name, $sformatf("%b", act), $sformatf("%b", exp));
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) note_fail(name, $sformatf("%0d", act), $sformatf("%0d", exp));
   endtask

   task automatic check_mask(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) note_fail(name, $sformatf("%h", act), $sformatf("%h", exp));
   endtask

   // ---------------------------------------------------------------- model
   // Level flips after DEB consecutive samples disagreeing with it; held
   // samples are those seen pressed whose previous sample was also pressed.
   typedef struct {
      logic pin_d1;
      logic pin_d2;
      logic level;
      int   run;
      int   held;
      logic prev_s;
      logic press;
      logic rel;
      logic lp;
      logic rep;
   } model_t;

   function automatic model_t model_reset(input logic active_low);
      model_t m;
      m.pin_d1 = active_low;
      m.pin_d2 = active_low;
      m.level  = 1'b0;
      m.run    = 0;
      m.held   = 0;
      m.prev_s = 1'b0;
      m.press  = 1'b0;
      m.rel    = 1'b0;
      m.lp     = 1'b0;
      m.rep    = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(input model_t m_in, input logic active_low,
                                         input logic en, input logic strobe, input logic pin);
      model_t m;
      logic   s;
      m        = m_in;
      s        = active_low ? ~m.pin_d2 : m.pin_d2;
      m.pin_d2 = m.pin_d1;
      m.pin_d1 = pin;
      m.press  = 1'b0;
      m.rel    = 1'b0;
      m.lp     = 1'b0;
      m.rep    = 1'b0;
      if (!en) begin
         m.level  = 1'b0;
         m.run    = 0;
         m.held   = 0;
         m.prev_s = 1'b0;
      end else if (strobe) begin
         if (m.level && s && m.prev_s) begin
            m.held++;
            if (m.held == LONG) m.lp = 1'b1;
            else if (m.held > LONG && (m.held - LONG) % REP == 0) m.rep = 1'b1;
         end
         if (s != m.level) begin
            m.run++;
            if (m.run == DEB) begin
               m.level = s;
               m.run   = 0;
               m.held  = 0;
               if (s) m.press = 1'b1;
               else   m.rel   = 1'b1;
            end
         end else begin
            m.run = 0;
         end
         m.prev_s = s;
      end
      return m;
   endfunction

   model_t ma, mb;

   // Per-cycle comparison of both instances against the model
   initial begin
      ma = model_reset(1'b1);
      mb = model_reset(1'b0);
      forever begin
         @(posedge Clock);
         if (!Reset) begin
            ma = model_reset(1'b1);
            mb = model_reset(1'b0);
         end else begin
            ma = model_step(ma, 1'b1, Enable_i, strobe_a, button_a);
            mb = model_step(mb, 1'b0, Enable_i, 1'b1, button_b);
         end
         #1;
         check_bit("a_state",   state_a, ma.level);
         check_bit("a_press",   press_a, ma.press);
         check_bit("a_release", rel_a,   ma.rel);
         check_bit("a_long",    lp_a,    ma.lp);
         check_bit("a_repeat",  rep_a,   ma.rep);
         check_bit("b_state",   state_b, mb.level);
         check_bit("b_press",   press_b, mb.press);
         check_bit("b_release", rel_b,   mb.rel);
         check_bit("b_long",    lp_b,    mb.lp);
         check_bit("b_repeat",  rep_b,   mb.rep);
      end
   end

   // ---------------------------------------------------------------- strobe + pulse log
   int cnt10 = 0;
   initial begin
      strobe_a = 1'b0;
      forever begin
         @(negedge Clock);
         cnt10    = (cnt10 == 9) ? 0 : cnt10 + 1;
         strobe_a = (cnt10 == 9);
      end
   end

   // hist_a[n] = {press, release, long, repeat} after strobe edge n
   logic [3:0] hist_a [0:4095];
   int strobe_no = 0;
   initial begin
      forever begin
         @(posedge Clock);
         if (strobe_a) begin
            #1;
            if (strobe_no < 4095) strobe_no++;
            hist_a[strobe_no] = {press_a, rel_a, lp_a, rep_a};
         end
      end
   end

   localparam int B_PRESS = 3, B_REL = 2, B_LONG = 1, B_REP = 0;

   function automatic logic [63:0] mask(input int base, input int n, input int which);
      logic [63:0] m;
      m = '0;
      for (int i = 1; i <= n && i < 64; i++) m[i] = hist_a[base + i][which];
      return m;
   endfunction

   // Advance to the negedge following the next strobe edge of instance A
   task automatic wait_strobe();
      int k;
      k = 0;
      do begin
         @(posedge Clock);
         k++;
      end while (!strobe_a && k < 20);
      if (!strobe_a) check_bit("strobe_timeout", strobe_a, 1'b1);
      @(negedge Clock);
   endtask

   task automatic run(input int n);
      repeat (n) wait_strobe();
   endtask

   // ---------------------------------------------------------------- directed
   int base;
   int press_at, press_cnt, rel_at;
   logic any_state;

   initial begin
      Reset    = 1'b0;
      Enable_i = 1'b1;
      button_a = 1'b1;
      button_b = 1'b0;
      repeat (3) @(negedge Clock);
      check_bit("reset_state_a", state_a, 1'b0);
      check_bit("reset_press_a", press_a, 1'b0);
      check_bit("reset_state_b", state_b, 1'b0);
      Reset = 1'b1;
      wait_strobe();

      // Clean press held 60 clocks, then release
      button_a = 1'b0; base = strobe_no; run(6);
      check_mask("clean_press_at", mask(base, 6, B_PRESS), 64'h10);
      check_mask("clean_no_long",  mask(base, 6, B_LONG),  64'h0);
      check_bit ("clean_state",    state_a, 1'b1);
      button_a = 1'b1; base = strobe_no; run(6);
      check_mask("clean_release_at", mask(base, 6, B_REL), 64'h10);
      check_bit ("clean_released",   state_a, 1'b0);

      // Bounce rejection: 0,0,1,0,0 then released
      base = strobe_no;
      button_a = 1'b0; run(2);
      button_a = 1'b1; run(1);
      button_a = 1'b0; run(2);
      button_a = 1'b1; run(6);
      check_mask("bounce_no_press", mask(base, 11, B_PRESS), 64'h0);
      check_mask("bounce_no_rel",   mask(base, 11, B_REL),   64'h0);
      check_bit ("bounce_state",    state_a, 1'b0);

      // Long press and auto-repeat over 30 strobes, then release
      button_a = 1'b0; base = strobe_no; run(30);
      check_mask("long_press_at",  mask(base, 30, B_PRESS), 64'h10);
      check_mask("long_long_at",   mask(base, 30, B_LONG),  64'h4000);
      check_mask("long_repeat_at", mask(base, 30, B_REP),   64'h2492_0000);
      button_a = 1'b1; base = strobe_no; run(6);
      check_mask("long_release_at", mask(base, 6, B_REL), 64'h10);
      check_mask("long_rel_norep",  mask(base, 6, B_REP), 64'h0);
      check_bit ("long_released",   state_a, 1'b0);

      // Release bounce in REPEAT: one released sample, then held again
      button_a = 1'b0; base = strobe_no; run(17);
      check_mask("rb_repeat_17", mask(base, 17, B_REP), 64'h2_0000);
      button_a = 1'b1; base = strobe_no; run(1);
      button_a = 1'b0; run(8);
      check_mask("rb_no_release", mask(base, 9, B_REL), 64'h0);
      check_mask("rb_spacing",    mask(base + 1, 8, B_REP), 64'h90);
      check_bit ("rb_still_held", state_a, 1'b1);

      // Enable low for one clock while in REPEAT
      Enable_i = 1'b0;
      @(negedge Clock);
      check_bit("en_state_low", state_a, 1'b0);
      check_bit("en_no_release", rel_a, 1'b0);
      Enable_i = 1'b1;
      base = strobe_no; run(20);
      check_mask("en_repress_at", mask(base, 20, B_PRESS), 64'h10);
      check_mask("en_relong_at",  mask(base, 20, B_LONG),  64'h4000);
      check_mask("en_no_rel",     mask(base, 20, B_REL),   64'h0);
      check_bit ("pre_reset_held", state_a, 1'b1);

      // Asynchronous reset mid-hold
      Reset = 1'b0;
      #1;
      check_bit("rst_state",   state_a, 1'b0);
      check_bit("rst_release", rel_a,   1'b0);
      check_bit("rst_repeat",  rep_a,   1'b0);
      button_a = 1'b1;
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      base = strobe_no; run(6);
      check_mask("post_rst_no_press", mask(base, 6, B_PRESS), 64'h0);
      check_mask("post_rst_no_rel",   mask(base, 6, B_REL),   64'h0);

      // Active-high instance, strobe every clock: 4-clock pulse is accepted
      button_b = 1'b1;
      press_at = 0; press_cnt = 0; rel_at = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge Clock);
         if (press_b) begin press_at = i; press_cnt++; end
         if (rel_b) rel_at = i;
         if (i == 4) button_b = 1'b0;
      end
      check_int("b4_press_edge",   press_at,  6);
      check_int("b4_press_count",  press_cnt, 1);
      check_int("b4_release_edge", rel_at,    10);

      // 3-clock pulse is rejected
      button_b = 1'b1;
      press_cnt = 0; any_state = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge Clock);
         if (press_b) press_cnt++;
         any_state = any_state | state_b;
         if (i == 3) button_b = 1'b0;
      end
      check_int("b3_no_press", press_cnt, 0);
      check_bit("b3_no_state", any_state, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
